// File: rtl/serializer_pkg.sv
// Shared types and sizing helpers for the word serializer slice.
package serializer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } serState_t;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_BEAT_W = 8;

  function automatic int beatsOf(input int width, input int beatW);
    return width / beatW;
  endfunction

  // A single-beat word still needs a 1-bit counter.
  function automatic int cntWidthOf(input int beats);
    return (beats <= 1) ? 1 : $clog2(beats);
  endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// Loadable parallel-in/serial-out shift register; load wins over shift.
module piso_shift_reg #(
  parameter int WIDTH     = 32,
  parameter int BEAT_W    = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              shift,
  input  logic [WIDTH-1:0]  dataIn,
  output logic [BEAT_W-1:0] beat
);

  logic [WIDTH-1:0] sr;

  generate
    if (MSB_FIRST != 0) begin : gMsb
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)       sr <= '0;
        else if (load)  sr <= dataIn;
        else if (shift) sr <= sr << BEAT_W;
      end
      assign beat = sr[WIDTH-1 -: BEAT_W];
    end else begin : gLsb
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)       sr <= '0;
        else if (load)  sr <= dataIn;
        else if (shift) sr <= sr >> BEAT_W;
      end
      assign beat = sr[BEAT_W-1:0];
    end
  endgenerate

endmodule

// File: rtl/word_serializer.sv
// Word-to-beat unloader with valid/ready on both sides and zero-bubble reload.
// Optional trailing even-parity beat enabled by defining SERIALIZER_PARITY_EN.
module word_serializer
  import serializer_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int BEAT_W    = DEF_BEAT_W,
  parameter int MSB_FIRST = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  dataIn,
  input  logic              inValid,
  output logic              inReady,
  output logic [BEAT_W-1:0] serOut,
  output logic              serValid,
  input  logic              serReady,
  output logic              serLast
);

  localparam int BEATS = beatsOf(WIDTH, BEAT_W);
  localparam int CW    = cntWidthOf(BEATS);
  localparam logic [CW-1:0] LAST_CNT = CW'(BEATS - 1);

  serState_t         state, nextState;
  logic [CW-1:0]     cnt;
  logic [BEAT_W-1:0] beat;
  logic              onLastData, xfer, load, shiftEn;

  assign onLastData = (state == SHIFT) && (cnt == LAST_CNT);
  assign xfer       = serValid & serReady;
  assign load       = inValid & inReady;
  assign shiftEn    = xfer & (state == SHIFT);

  piso_shift_reg #(
    .WIDTH(WIDTH), .BEAT_W(BEAT_W), .MSB_FIRST(MSB_FIRST)
  ) uSr (
    .clk(clk), .rst(rst), .load(load), .shift(shiftEn),
    .dataIn(dataIn), .beat(beat)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nextState;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         cnt <= '0;
    else if (load)    cnt <= '0;
    else if (shiftEn) cnt <= cnt + 1'b1;
  end

`ifdef SERIALIZER_PARITY_EN
  logic parityQ;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      parityQ <= 1'b0;
    else if (load) parityQ <= ^dataIn;
  end
`endif

  always_comb begin
    nextState = state;
    case (state)
      IDLE:  if (load) nextState = SHIFT;
`ifdef SERIALIZER_PARITY_EN
      SHIFT:  if (xfer && onLastData) nextState = PARITY;
      PARITY: if (xfer) nextState = load ? SHIFT : IDLE;
`else
      SHIFT:  if (xfer && onLastData) nextState = load ? SHIFT : IDLE;
`endif
      default: nextState = IDLE;
    endcase
  end

  // inReady depends combinationally on serReady so a new word lands on the last-beat edge.
  always_comb begin
    serValid = (state != IDLE);
    serOut   = '0;
    serLast  = 1'b0;
    case (state)
      SHIFT: begin
        serOut = beat;
`ifndef SERIALIZER_PARITY_EN
        serLast = onLastData;
`endif
      end
`ifdef SERIALIZER_PARITY_EN
      PARITY: begin
        serOut  = BEAT_W'(parityQ);
        serLast = 1'b1;
      end
`endif
      default: ;
    endcase
    inReady = (state == IDLE) | (serLast & serReady);
  end

endmodule

// File: tb/tb_word_serializer.sv
// Directed bench for word_serializer with a beat-queue reference model.
module tb_word_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] dataIn;
  logic        inValid, serReady;
  logic        inReady, serValid, serLast;
  logic [7:0]  serOut;
  logic        lsbReady, lsbValid, lsbLast;
  logic [7:0]  lsbOut;

  int total = 0;
  int bad   = 0;

  logic [8:0] model[$];
  logic [8:0] cap[$];
  logic [8:0] capL[$];
  logic       expReady;

  always #5 clk = ~clk;

  word_serializer #(.WIDTH(32), .BEAT_W(8), .MSB_FIRST(1)) dut (
    .clk(clk), .rst(rst), .dataIn(dataIn), .inValid(inValid), .inReady(inReady),
    .serOut(serOut), .serValid(serValid), .serReady(serReady), .serLast(serLast)
  );

  word_serializer #(.WIDTH(32), .BEAT_W(8), .MSB_FIRST(0)) dutLsb (
    .clk(clk), .rst(rst), .dataIn(dataIn), .inValid(inValid), .inReady(lsbReady),
    .serOut(lsbOut), .serValid(lsbValid), .serReady(serReady), .serLast(lsbLast)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: a word becomes BEATS entries {last, data}, optionally a parity entry.
  task automatic pushWord(input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      logic [7:0] b;
      b = 8'(w >> (8 * (3 - i)));
`ifdef SERIALIZER_PARITY_EN
      model.push_back({1'b0, b});
`else
      model.push_back({(i == 3), b});
`endif
    end
`ifdef SERIALIZER_PARITY_EN
    model.push_back({1'b1, 7'd0, ^w});
`endif
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      model.delete();
      check("rst_serValid", 32'(serValid), 32'd0);
      check("rst_serOut",   32'(serOut),   32'd0);
      check("rst_serLast",  32'(serLast),  32'd0);
      check("rst_inReady",  32'(inReady),  32'd1);
    end else begin
      expReady = (model.size() == 0) || (model.size() == 1 && serReady);
      check("inReady",  32'(inReady),  32'(expReady));
      check("serValid", 32'(serValid), 32'(model.size() != 0));
      if (model.size() != 0) begin
        check("serOut",  32'(serOut),  32'(model[0][7:0]));
        check("serLast", 32'(serLast), 32'(model[0][8]));
      end
      if (serValid && serReady) cap.push_back({serLast, serOut});
      if (lsbValid && serReady) capL.push_back({lsbLast, lsbOut});
      if (model.size() != 0 && serReady) void'(model.pop_front());
      if (inValid && expReady) pushWord(dataIn);
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic sendWord(input logic [31:0] w);
    logic acc;
    inValid = 1'b1;
    dataIn  = w;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      acc = inReady;
      @(posedge clk); #1;
      if (acc) return;
    end
    total++; bad++;
    $display("FAIL accept_timeout: word %h not accepted, required within 50 cycles", w);
  endtask

  task automatic waitBeats(input int n);
    for (int i = 0; i < 100 && cap.size() < n; i++) step();
    repeat (2) step();
  endtask

  // Builds a literal expected sequence; parity entry appended only in the parity build.
  function automatic void mkSeq(input logic [7:0] b[$], input bit par, output logic [8:0] s[$]);
    s.delete();
    foreach (b[i]) begin
`ifdef SERIALIZER_PARITY_EN
      s.push_back({1'b0, b[i]});
      if (i % 4 == 3) s.push_back({1'b1, 7'd0, par});
`else
      s.push_back({(i % 4 == 3), b[i]});
`endif
    end
  endfunction

  task automatic chkSeq(input string nm, input logic [8:0] got[$], input logic [8:0] exp[$]);
    check({nm, "_count"}, 32'(got.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      check($sformatf("%s_beat%0d", nm, i), 32'(got[i]), 32'(exp[i]));
  endtask

  initial begin
    logic [8:0] e[$];
    logic [7:0] b[$];
    logic       pat[$];
    rst = 1'b0; inValid = 1'b0; serReady = 1'b0; dataIn = '0;

    // 1: reset with garbage inputs
    repeat (4) begin
      step();
      inValid = 1'($urandom); dataIn = $urandom; serReady = 1'($urandom);
    end
    inValid = 1'b0; serReady = 1'b1;
    rst = 1'b1;
    repeat (3) step();
    check("idle_no_beats", 32'(cap.size()), 32'd0);

    // 2: plain word, downstream always ready
    cap.delete(); capL.delete();
    sendWord(32'hDEADBEEF); inValid = 1'b0;
    waitBeats(4);
    b = '{8'hDE, 8'hAD, 8'hBE, 8'hEF}; mkSeq(b, 1'b0, e);
    chkSeq("msb_first", cap, e);
    b = '{8'hEF, 8'hBE, 8'hAD, 8'hDE}; mkSeq(b, 1'b0, e);
    chkSeq("lsb_first", capL, e);

    // 3: stalls
    cap.delete();
    serReady = 1'b0;
    sendWord(32'hDEADBEEF); inValid = 1'b0;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    foreach (pat[i]) begin
      serReady = pat[i];
      step();
    end
    serReady = 1'b1;
    waitBeats(4);
    b = '{8'hDE, 8'hAD, 8'hBE, 8'hEF}; mkSeq(b, 1'b0, e);
    chkSeq("stall", cap, e);

    // 4: back-to-back words
    cap.delete();
    sendWord(32'h01020304);
    sendWord(32'hA0B0C0D0); inValid = 1'b0;
    waitBeats(8);
    b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hA0, 8'hB0, 8'hC0, 8'hD0};
    s4: begin
      logic [8:0] e2[$];
      mkSeq(b[0:3], 1'b1, e);
      mkSeq(b[4:7], 1'b0, e2);
      e = {e, e2};
    end
    chkSeq("b2b", cap, e);

    // 5: reset mid-word
    cap.delete();
    sendWord(32'hDEADBEEF); inValid = 1'b0;
    step(); step();
    rst = 1'b0;
    step(); step();
    rst = 1'b1;
    step();
    e = '{9'h0DE, 9'h0AD};
    chkSeq("abort", cap, e);
    cap.delete();
    sendWord(32'h11223344); inValid = 1'b0;
    waitBeats(4);
    b = '{8'h11, 8'h22, 8'h33, 8'h44}; mkSeq(b, 1'b0, e);
    chkSeq("after_abort", cap, e);

`ifdef SERIALIZER_PARITY_EN
    // 6: parity beat values
    cap.delete();
    sendWord(32'h00000007); inValid = 1'b0;
    waitBeats(5);
    e = '{9'h000, 9'h000, 9'h000, 9'h007, 9'h101};
    chkSeq("parity_odd", cap, e);
    cap.delete();
    sendWord(32'h00000003); inValid = 1'b0;
    waitBeats(5);
    e = '{9'h000, 9'h000, 9'h000, 9'h003, 9'h100};
    chkSeq("parity_even", cap, e);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
